// File: rtl/pam_pkg.sv
// pam_pkg: shared constants, saturating add and stage-2 state encoding
package pam_pkg;
  localparam int PROD_W = 16;
  typedef enum logic {ACC, HOLD_STALL} acc_state_t;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] max);
    logic [63:0] s;
    s = a + b;
    return (s > max) ? max : s;
  endfunction
endpackage

// File: rtl/pam_skid_buffer.sv
// pam_skid_buffer: 2-entry in-order valid/ready buffer
module pam_skid_buffer #(
  parameter int W = pam_pkg::PROD_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import pam_pkg::*;
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, push, pop;
  logic [1:0] cnt;
  // ready is forced low while reset is asserted so nothing is taken in that cycle
  assign in_ready  = ~rst & (cnt != 2'd2);
  assign out_valid = cnt != 2'd0;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      cnt    <= cnt + 2'(push) - 2'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
endmodule

// File: rtl/approx_product_accumulator.sv
// approx_product_accumulator: saturating per-vector dot-product accumulator
module approx_product_accumulator #(
  parameter int PROD_W  = pam_pkg::PROD_W,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PROD_W-1:0]              in_prod,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]   out_count,
  output logic                           out_ovf,
  output logic                           out_trunc
);
  import pam_pkg::*;
  localparam int CNT_W = $clog2(MAX_LEN+1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  logic buf_valid, pop, load, last, close, ovf_r, ovf_now, stall;
  logic [PROD_W:0] buf_data;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  acc_state_t state, state_n;

  pam_skid_buffer #(.W(PROD_W+1)) u_skid (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data({in_prod, in_last}),
    .out_valid(buf_valid), .out_ready(pop), .out_data(buf_data)
  );

  assign {prod, last} = buf_data;

  always_comb begin
    acc_n   = ACC_W'(sat_add(64'(acc), 64'(prod), 64'(ACC_MAX)));
    ovf_now = (64'(acc) + 64'(prod)) > 64'(ACC_MAX);
    cnt_n   = cnt + 1'b1;
    close   = last | (cnt_n == CNT_W'(MAX_LEN));
    stall   = buf_valid & close & out_valid & ~out_ready;
  end

  always_ff @(posedge clk)
    state <= rst ? ACC : state_n;

  always_comb state_n = stall ? HOLD_STALL : ACC;

  // a held close pops exactly when the output register drains
  always_comb begin
    pop  = (state == HOLD_STALL) ? out_ready : buf_valid & ~stall;
    load = pop & close;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else if (pop) begin
      acc   <= close ? '0 : acc_n;
      cnt   <= close ? '0 : cnt_n;
      ovf_r <= close ? 1'b0 : ovf_r | ovf_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        out_sum   <= acc_n;
        out_count <= cnt_n;
        out_ovf   <= ovf_r | ovf_now;
        out_trunc <= ~last;
      end
    end
  end
endmodule
